sbox_sequencer: RTL

Controller that shares one masked S-box datapath (`clm_sbox`-style: a 7-stage multiplicative-inverse-plus-affine pipeline without overlap) across a vector of NB masked bytes. The vector is 16 state bytes plus 4 key-schedule bytes by default. The sequencer captures the vector on `start` and issues one element per S-box pass. It collects each result into an output buffer, then pulses `done`. It sits between the round controller and the S-box instance, and it also paces the external mask RNG.

---
 rtl/sbox_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sbox_sequencer.sv
// sbox_sequencer
//
// Shares one masked S-box pipeline across a vector of NB masked elements.
// A run is started by a single-cycle request while idle. The vector is then
// fed through the S-box one element per pass (1 issue cycle + wait cycles),
// and each result is collected into a registered output buffer. A one-cycle
// done pulse ends the run. If a pass never returns within TIMEOUT wait
// cycles, the sticky err flag is raised and the run ends early.
//
// Parameters:
//   m, d     element width is m+d bits (masked byte plus mask share bits)
//   NB       number of elements per run (>= 1)
//   TIMEOUT  maximum wait cycles per element before err is raised (>= 1)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous reset, active-high
//   start      run request, only honoured while idle
//   in_vec     NB input elements, captured on an accepted start
//   out_vec    NB registered results
//   busy       high in every state except idle
//   done       one-cycle completion pulse
//   err        sticky timeout flag, cleared by the next accepted start
//   rnd_adv    one-cycle pulse asking the RNG for fresh S-box masks
//   sb_in      element presented to the S-box
//   sb_drdy_i  S-box start strobe
//   sb_out     S-box result
//   sb_drdy_o  S-box result-valid strobe
module sbox_sequencer #(
  parameter int m       = 8,
  parameter int d       = 8,
  parameter int NB      = 20,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NB-1:0][m+d-1:0]  in_vec,
  output logic [NB-1:0][m+d-1:0]  out_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    rnd_adv,
  output logic [m+d-1:0]          sb_in,
  output logic                    sb_drdy_i,
  input  logic [m+d-1:0]          sb_out,
  input  logic                    sb_drdy_o
);

  localparam int W  = m + d;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);
  localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         wcnt;
  logic [NB-1:0][W-1:0]  in_buf;
  logic [NB-1:0][W-1:0]  out_buf;

  // The S-box samples its input over two stages, so the selected element is
  // driven continuously from the captured buffer rather than only while
  // issuing. Selection is an explicit compare so an idx value past NB-1
  // (unreachable, but representable when NB is not a power of two) is safe.
  always_comb begin
    sb_in = '0;
    for (int k = 0; k < NB; k++) begin
      if (idx == IW'(k)) begin
        sb_in = in_buf[k];
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sb_drdy_i = (state == ISSUE);
  assign rnd_adv   = (state == ISSUE);
  assign out_vec   = out_buf;

  // Sequencing: capture on start, then alternate ISSUE / WAIT per element.
  // A result strobe is only honoured in WAIT, so stray strobes elsewhere
  // never write the buffer or move the index. On timeout the partially
  // filled buffer is left as-is for inspection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      wcnt    <= '0;
      err     <= 1'b0;
      in_buf  <= '0;
      out_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            in_buf <= in_vec;
            idx    <= '0;
            err    <= 1'b0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (sb_drdy_o) begin
            for (int k = 0; k < NB; k++) begin
              if (idx == IW'(k)) begin
                out_buf[k] <= sb_out;
              end
            end
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
          end else if (wcnt == WCNT_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
